// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin front end that shares one sequential
// add/subtract unit among N_REQ requesters. It grants one requester at a time,
// latches its operands, starts the adder and returns the result (or a timeout
// error) with a one-cycle acknowledge.
module adder_rr_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    input  logic [N_REQ-1:0]       op_sub,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       res_out,
    output logic                   err,
    output logic                   busy,
    output logic                   add_start,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_sub,
    input  logic                   add_done,
    input  logic [WIDTH-1:0]       add_res
);

    localparam int         IDX_W       = $clog2(N_REQ);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;        // requester currently being served
    logic [IDX_W-1:0]   last;       // requester served most recently
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [7:0]         watchdog;
    logic [WIDTH-1:0]   res_q;
    logic               err_q;

    // Round-robin pick: first pending request after the last one served, with wrap.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_idx   = last;
        pick_valid = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_valid && req[(int'(last) + k) % N_REQ]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((int'(last) + k) % N_REQ);
            end
        end
    end

    // Next-state logic; a done in the timeout cycle still counts as success.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (add_done || watchdog == TIMEOUT_CNT) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the datapath registers each state updates.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            idx      <= '0;
            last     <= IDX_W'(N_REQ - 1);
            add_a    <= '0;
            add_b    <= '0;
            add_sub  <= 1'b0;
            watchdog <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        idx     <= pick_idx;
                        add_a   <= op_a[int'(pick_idx)*WIDTH +: WIDTH];
                        add_b   <= op_b[int'(pick_idx)*WIDTH +: WIDTH];
                        add_sub <= op_sub[pick_idx];
                    end
                end
                ISSUE: watchdog <= '0;
                WAIT: begin
                    watchdog <= watchdog + 8'd1;
                    if (add_done) begin
                        res_q <= add_res;
                        err_q <= 1'b0;
                    end else if (watchdog == TIMEOUT_CNT) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                ACK: begin
                    last  <= idx;
                    res_q <= '0;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Grant, acknowledge and handshake outputs decoded from the state.
    always_comb begin
        gnt = '0;
        ack = '0;
        if (state != IDLE) gnt[idx] = 1'b1;
        if (state == ACK)  ack[idx] = 1'b1;
    end

    assign add_start = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign res_out   = res_q;
    assign err       = err_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed sequence with randomized operands, an adder
// responder driven from the stimulus, and a round-robin reference model.
module tb_adder_rr_scheduler;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   RESET = 1'b1;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] op_a = '0;
    logic [N_REQ*WIDTH-1:0] op_b = '0;
    logic [N_REQ-1:0]       op_sub = '0;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       res_out;
    logic                   err;
    logic                   busy;
    logic                   add_start;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic                   add_sub;
    logic                   add_done = 1'b0;
    logic [WIDTH-1:0]       add_res = '0;

    int errors = 0;
    int checks = 0;
    int last_m = N_REQ - 1;   // reference round-robin pointer

    adder_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .RESET(RESET), .req(req), .op_a(op_a), .op_b(op_b),
        .op_sub(op_sub), .gnt(gnt), .ack(ack), .res_out(res_out), .err(err),
        .busy(busy), .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_sub(add_sub), .add_done(add_done), .add_res(add_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] ref_alu(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic s);
        return s ? WIDTH'(a - b) : WIDTH'(a + b);
    endfunction

    task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s);
        op_a[i*WIDTH +: WIDTH] = a;
        op_b[i*WIDTH +: WIDTH] = b;
        op_sub[i]              = s;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N_REQ; i++) set_op(i, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET    = 1'b1;
        req      = '0;
        add_done = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {gnt, ack, res_out, err, busy, add_start, add_a, add_b, add_sub}, '0);
        RESET  = 1'b0;
        last_m = N_REQ - 1;
    endtask

    // One operation: lat = WAIT cycle in which add_done is driven (<1 = never).
    task automatic run_op(input int lat, input bit drop, input bit scramble,
                          input bit force_res, input logic [WIDTH-1:0] forced,
                          output int w);
        logic [WIDTH-1:0] ea, eb, eres;
        logic             es;
        bit               seen, tmo, gnt_bad;
        int               ack_cyc, extra;
        w = rr_pick(req, last_m);
        if (w < 0) begin
            check("no_pending_request", 0, 1);
            return;
        end
        ea   = op_a[w*WIDTH +: WIDTH];
        eb   = op_b[w*WIDTH +: WIDTH];
        es   = op_sub[w];
        eres = force_res ? forced : ref_alu(ea, eb, es);
        tmo  = (lat < 1) || (lat > TIMEOUT + 1);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (add_start === 1'b1) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 1);
        if (!seen) return;
        check("issue_gnt", 64'(gnt), 64'(1 << w));
        check("issue_operands", {add_a, add_b, add_sub}, {ea, eb, es});
        if (scramble) begin
            op_a   = $urandom;
            op_b   = $urandom;
            op_sub = ~op_sub;
            req[w] = 1'b0;
        end
        seen = 1'b0; extra = 0; gnt_bad = 1'b0; ack_cyc = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (add_start === 1'b1) extra++;
            if (gnt !== 4'(1 << w)) gnt_bad = 1'b1;
            if (ack !== '0) begin
                seen     = 1'b1;
                ack_cyc  = c;
                add_done = 1'b0;
            end else begin
                add_done = (c == lat);
                add_res  = (c == lat) ? eres : 8'($urandom);
            end
        end
        check("ack_seen", 64'(seen), 1);
        if (!seen) return;
        check("ack_onehot", 64'(ack), 64'(1 << w));
        check("ack_result", {res_out, err}, {(tmo ? 8'h00 : eres), tmo});
        check("ack_latency", 64'(ack_cyc), 64'(tmo ? TIMEOUT + 2 : lat + 1));
        check("single_start", 64'(extra), 0);
        check("gnt_held", 64'(gnt_bad), 0);
        check("operands_kept", {add_a, add_b, add_sub}, {ea, eb, es});
        if (drop) req[w] = 1'b0;
        last_m = w;
        @(negedge clk);
        check("idle_after_ack", {gnt, ack, res_out, err, busy}, '0);
    endtask

    initial begin : stimulus
        int w;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        bit seen;

        // Reset state.
        do_reset();

        // Single request, operands changed and req dropped after grant.
        set_op(0, 8'h05, 8'hFD, 1'b0);
        req = 4'b0001;
        run_op(6, 1, 1, 1, 8'h02, w);
        check("single_winner", 64'(w), 0);

        // Contention from reset: 0 before 2.
        do_reset();
        randomize_ops();
        req = 4'b0101;
        run_op(int'($urandom_range(1, 10)), 1, 0, 0, 8'h00, w);
        check("contention_first", 64'(w), 0);
        run_op(int'($urandom_range(1, 10)), 1, 0, 0, 8'h00, w);
        check("contention_second", 64'(w), 2);

        // Fairness with all requests held; first op at minimum latency.
        do_reset();
        randomize_ops();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            run_op((i == 0) ? 1 : int'($urandom_range(1, 12)), 0, 0, 0, 8'h00, w);
            check("fair_order", 64'(w), 64'(order[i]));
        end
        req = '0;

        // Timeout abort, then a normal request.
        randomize_ops();
        req = 4'b0010;
        run_op(-1, 1, 0, 0, 8'h00, w);
        req = 4'b1000;
        run_op(4, 1, 0, 0, 8'h00, w);
        check("after_timeout_winner", 64'(w), 3);

        // Done on the exact timeout cycle wins.
        req = 4'b0001;
        run_op(TIMEOUT + 1, 1, 0, 1, 8'h7F, w);

        // Reset during WAIT, then a stale add_done.
        randomize_ops();
        req  = 4'b0100;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (add_start === 1'b1) seen = 1'b1;
        end
        check("midwait_start_seen", 64'(seen), 1);
        repeat (3) @(negedge clk);
        RESET = 1'b1;
        req   = '0;
        #1;
        check("midwait_reset_outputs",
              {gnt, ack, res_out, err, busy, add_start, add_a, add_b, add_sub}, '0);
        @(negedge clk);
        RESET  = 1'b0;
        last_m = N_REQ - 1;
        repeat (2) @(negedge clk);
        add_done = 1'b1;
        add_res  = 8'h55;
        @(negedge clk);
        add_done = 1'b0;
        check("stale_done_ignored", {gnt, ack, res_out, err, busy, add_start}, '0);
        req = 4'b1111;
        run_op(3, 0, 0, 0, 8'h00, w);
        check("post_reset_winner", 64'(w), 0);
        req = '0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
